// File: rtl/counterup16_1clk_negedge_async_resetn_period_pkg.sv
// Shared definitions for the negedge period-timer counter family:
// FSM state encoding and the default datapath width.
package counterup16_1clk_negedge_async_resetn_period_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counterup16_1clk_negedge_async_resetn_period_cmp_eq.sv
// WIDTH-bit equality comparator of the running count against the terminal period.
module counter_cmp_eq #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_equal
);

    assign o_equal = (i_count == i_period);

endmodule

// File: rtl/counterup16_1clk_negedge_async_resetn_period.sv
// 16-bit falling-edge up counter used as a period timer: counts to a programmable
// terminal value, then wraps (free-run) or stops (one-shot), pulsing tc on terminal count.
module counterup16_1clk_negedge_async_resetn_period
    import counterup16_1clk_negedge_async_resetn_period_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             enable,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    state_t           r_state;
    logic             w_atPeriod;

    counter_cmp_eq #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .i_count  (r_count),
        .i_period (period),
        .o_equal  (w_atPeriod)
    );

    // Priority per edge: clear, then load, then start, then count advance.
    always_ff @(negedge clock0 or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_VALUE;
            r_tc    <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_tc <= 1'b0;
            if (clear) begin
                r_count <= RESET_VALUE;
                r_state <= IDLE;
            end else if (load) begin
                r_count <= load_value;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            if (w_atPeriod) begin
                                r_tc <= 1'b1;
                                if (oneshot) begin
                                    r_state <= DONE;
                                end else begin
                                    r_count <= '0;
                                end
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            r_count <= '0;
                            r_state <= RUN;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign running = (r_state == RUN);
    assign done    = (r_state == DONE);

endmodule
